display_scheduler: RTL



---
 rtl/display_pkg.sv | 24 ++
 rtl/display_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the seven-segment display scheduler.
package display_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned VALUE_W = 32;
  localparam int unsigned MASK_W  = 8;

  localparam logic [ADDR_W-1:0] DISP_ADDR_LO   = 3'b000;
  localparam logic [ADDR_W-1:0] DISP_ADDR_HI   = 3'b010;
  localparam logic [ADDR_W-1:0] DISP_ADDR_MASK = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_WR,
    S_DBG_LO,
    S_DBG_HI,
    S_DBG_MASK,
    S_RST_LO,
    S_RST_HI,
    S_RST_MASK
  } state_e;

endpackage

// File: rtl/display_scheduler.sv
// Arbitrates CPU and debug writes to the display, shadows CPU state and
// replays it to the display when the debug overlay is released.
module display_scheduler
  import display_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ack,
  input  logic               dbg_hold,
  input  logic               dbg_req,
  input  logic [VALUE_W-1:0] dbg_value,
  input  logic [MASK_W-1:0]  dbg_mask,
  output logic               dbg_ack,
  output logic               disp_write_enable,
  output logic               disp_select,
  output logic [ADDR_W-1:0]  disp_address,
  output logic [DATA_W-1:0]  disp_write_data
);

  state_e             state_q;
  logic [DATA_W-1:0]  sh_lo_q;
  logic [DATA_W-1:0]  sh_hi_q;
  logic [MASK_W-1:0]  sh_mask_q;
  logic [DATA_W-1:0]  dbg_hi_q;
  logic [MASK_W-1:0]  dbg_mask_q;
  logic               hold_prev_q;
  logic               restore_pending_q;
  logic               sel_arm_q;

  logic addr_ok_c;
  logic hold_fall_c;
  logic restoring_c;
  logic dbg_go_c;
  logic cpu_go_c;

  assign addr_ok_c   = (cpu_addr == DISP_ADDR_LO) || (cpu_addr == DISP_ADDR_HI) ||
                       (cpu_addr == DISP_ADDR_MASK);
  assign hold_fall_c = hold_prev_q & ~dbg_hold;
  assign restoring_c = (state_q == S_RST_LO) || (state_q == S_RST_HI) ||
                       (state_q == S_RST_MASK);
  assign dbg_go_c    = dbg_hold & dbg_req;
  // The ack cycle still sees the level request, so it must not re-accept it.
  assign cpu_go_c    = cpu_req & ~cpu_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      sh_lo_q           <= '0;
      sh_hi_q           <= '0;
      sh_mask_q         <= '0;
      dbg_hi_q          <= '0;
      dbg_mask_q        <= '0;
      hold_prev_q       <= 1'b0;
      restore_pending_q <= 1'b0;
      sel_arm_q         <= 1'b0;
      cpu_ack           <= 1'b0;
      dbg_ack           <= 1'b0;
      disp_write_enable <= 1'b0;
      disp_select       <= 1'b0;
      disp_address      <= '0;
      disp_write_data   <= '0;
    end else begin
      cpu_ack           <= 1'b0;
      dbg_ack           <= 1'b0;
      disp_write_enable <= 1'b0;
      hold_prev_q       <= dbg_hold;
      // Select rises one cycle late and then never drops, so contents persist.
      sel_arm_q         <= 1'b1;
      disp_select       <= sel_arm_q;

      if (hold_fall_c) begin
        restore_pending_q <= 1'b1;
      end else if (dbg_hold && !restoring_c) begin
        restore_pending_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (restore_pending_q) begin
            disp_write_enable <= 1'b1;
            disp_address      <= DISP_ADDR_LO;
            disp_write_data   <= sh_lo_q;
            state_q           <= S_RST_LO;
          end else if (dbg_go_c) begin
            dbg_hi_q          <= dbg_value[31:16];
            dbg_mask_q        <= dbg_mask;
            disp_write_enable <= 1'b1;
            disp_address      <= DISP_ADDR_LO;
            disp_write_data   <= dbg_value[15:0];
            state_q           <= S_DBG_LO;
          end else if (cpu_go_c) begin
            cpu_ack <= 1'b1;
            if (addr_ok_c) begin
              case (cpu_addr)
                DISP_ADDR_LO: sh_lo_q   <= cpu_wdata;
                DISP_ADDR_HI: sh_hi_q   <= cpu_wdata;
                default:      sh_mask_q <= cpu_wdata[7:0];
              endcase
              if (!dbg_hold) begin
                disp_write_enable <= 1'b1;
                disp_address      <= cpu_addr;
                disp_write_data   <= (cpu_addr == DISP_ADDR_MASK) ?
                                     {8'h00, cpu_wdata[7:0]} : cpu_wdata;
                state_q           <= S_CPU_WR;
              end
            end
          end
        end
        S_CPU_WR:   state_q <= S_IDLE;
        S_DBG_LO: begin
          disp_write_enable <= 1'b1;
          disp_address      <= DISP_ADDR_HI;
          disp_write_data   <= dbg_hi_q;
          state_q           <= S_DBG_HI;
        end
        S_DBG_HI: begin
          disp_write_enable <= 1'b1;
          disp_address      <= DISP_ADDR_MASK;
          disp_write_data   <= {8'h00, dbg_mask_q};
          dbg_ack           <= 1'b1;
          state_q           <= S_DBG_MASK;
        end
        S_DBG_MASK: state_q <= S_IDLE;
        S_RST_LO: begin
          disp_write_enable <= 1'b1;
          disp_address      <= DISP_ADDR_HI;
          disp_write_data   <= sh_hi_q;
          state_q           <= S_RST_HI;
        end
        S_RST_HI: begin
          disp_write_enable <= 1'b1;
          disp_address      <= DISP_ADDR_MASK;
          disp_write_data   <= {8'h00, sh_mask_q};
          state_q           <= S_RST_MASK;
        end
        S_RST_MASK: begin
          state_q <= S_IDLE;
          if (!hold_fall_c) begin
            restore_pending_q <= 1'b0;
          end
        end
        default:    state_q <= S_IDLE;
      endcase
    end
  end

endmodule
